// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizes for the two-client SRAM arbiter.
package sram_arb_pkg;
  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 5;
  localparam int TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/sram_arbiter_if.sv
// Client, controller and hold signals of the SRAM arbiter; the arbiter sits on the slave side.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic              i_hold;
  logic              i_c0_req,   i_c1_req;
  logic              i_c0_wr,    i_c1_wr;
  logic [ADDR_W-1:0] i_c0_addr,  i_c1_addr;
  logic [DATA_W-1:0] i_c0_wdata, i_c1_wdata;
  logic              o_c0_ack,   o_c1_ack;
  logic [DATA_W-1:0] o_c_rdata;
  logic              o_c_err;
  logic              o_mem_req;
  logic              o_mem_wr;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_wait;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_hold, i_c0_req, i_c1_req, i_c0_wr, i_c1_wr, i_c0_addr, i_c1_addr,
           i_c0_wdata, i_c1_wdata, i_mem_wait, i_mem_rdata,
    output o_c0_ack, o_c1_ack, o_c_rdata, o_c_err, o_mem_req, o_mem_wr,
           o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_hold, i_c0_req, i_c1_req, i_c0_wr, i_c1_wr, i_c0_addr, i_c1_addr,
           i_c0_wdata, i_c1_wdata, i_mem_wait, i_mem_rdata,
    input  o_c0_ack, o_c1_ack, o_c_rdata, o_c_err, o_mem_req, o_mem_wr,
           o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin picker: on contention the client not granted last wins.
module sram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/sram_arbiter.sv
// Serialises two clients onto one SRAM controller, one transaction in flight at a time.
//   state | meaning
//   IDLE  | wait for a request while hold is low, latch the winner's command
//   ISSUE | one-cycle request pulse to the controller
//   WAIT  | wait for the controller, abort after TIMEOUT cycles
//   RESP  | one-cycle ack to the granted client with rdata/err
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sram_arbiter_if.slave  bus
);
  localparam logic [1:0]       IDLE     = S_IDLE;
  localparam logic [1:0]       ISSUE    = S_ISSUE;
  localparam logic [1:0]       WAIT     = S_WAIT;
  localparam logic [1:0]       RESP     = S_RESP;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              last_q,  last_d;
  logic              wr_q,    wr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic [1:0]        grant;

  sram_arb_rr u_rr (
    .req   ({bus.i_c1_req, bus.i_c0_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (!bus.i_hold && (grant != 2'b00)) begin
          last_d  = grant[1];
          wr_d    = grant[1] ? bus.i_c1_wr    : bus.i_c0_wr;
          addr_d  = grant[1] ? bus.i_c1_addr  : bus.i_c0_addr;
          wdata_d = grant[1] ? bus.i_c1_wdata : bus.i_c0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus.i_mem_wait) begin
          rdata_d = bus.i_mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // The last permitted WAIT cycle: the counter reaches TIMEOUT on leaving it.
          if (cnt_q == CNT_LAST) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      wr_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // last_q doubles as the id of the client owning the transaction in flight.
  assign bus.o_c0_ack    = (state_q == RESP) && !last_q;
  assign bus.o_c1_ack    = (state_q == RESP) &&  last_q;
  assign bus.o_c_rdata   = rdata_q;
  assign bus.o_c_err     = err_q;
  assign bus.o_mem_req   = (state_q == ISSUE);
  assign bus.o_mem_wr    = wr_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an expected-ack scoreboard.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  typedef struct packed {
    logic              client;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  int     n_vec = 0;
  int     n_err = 0;
  exp_t   sb[$];

  sram_arbiter_if bus();

  sram_arbiter #(.TIMEOUT(31)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_mem_req"},   32'(bus.o_mem_req),   32'd0);
    check({tag, "_mem_wr"},    32'(bus.o_mem_wr),    32'd1);
    check({tag, "_mem_addr"},  32'(bus.o_mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.o_mem_wdata), 32'd0);
    check({tag, "_ack0"},      32'(bus.o_c0_ack),    32'd0);
    check({tag, "_ack1"},      32'(bus.o_c1_ack),    32'd0);
    check({tag, "_rdata"},     32'(bus.o_c_rdata),   32'd0);
    check({tag, "_err"},       32'(bus.o_c_err),     32'd0);
  endtask

  task automatic expect_ack(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_ack0"},  32'(bus.o_c0_ack),  32'(!e.client));
      check({tag, "_ack1"},  32'(bus.o_c1_ack),  32'(e.client));
      check({tag, "_rdata"}, 32'(bus.o_c_rdata), 32'(e.rdata));
      check({tag, "_err"},   32'(bus.o_c_err),   32'(e.err));
    end
  endtask

  task automatic wait_for_ack(input string tag, input int budget);
    int n = 0;
    while (!(bus.o_c0_ack || bus.o_c1_ack) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_ack_seen"}, 32'(bus.o_c0_ack | bus.o_c1_ack), 32'd1);
    if (bus.o_c0_ack || bus.o_c1_ack) expect_ack(tag);
  endtask

  task automatic wait_mem_req(input string tag, input int budget);
    int n = 0;
    while (!bus.o_mem_req && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_mem_req_seen"}, 32'(bus.o_mem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst             = 1'b1;
    bus.i_hold      = 1'b0;
    bus.i_c0_req    = 1'b0;  bus.i_c1_req   = 1'b0;
    bus.i_c0_wr     = 1'b1;  bus.i_c1_wr    = 1'b1;
    bus.i_c0_addr   = '0;    bus.i_c1_addr  = '0;
    bus.i_c0_wdata  = '0;    bus.i_c1_wdata = '0;
    bus.i_mem_wait  = 1'b1;
    bus.i_mem_rdata = '0;
    #2;
    check_reset_outs("reset");
    tick();
    tick();
    rst = 1'b0;

    // c0 read, controller busy for 8 WAIT cycles, exact latency
    bus.i_c0_req  = 1'b1;
    bus.i_c0_wr   = 1'b1;
    bus.i_c0_addr = 20'h00010;
    sb.push_back('{client: 1'b0, rdata: 16'hBEEF, err: 1'b0});
    tick();
    check("t1_issue",    32'(bus.o_mem_req),  32'd1);
    check("t1_issue_wr", 32'(bus.o_mem_wr),   32'd1);
    check("t1_issue_ad", 32'(bus.o_mem_addr), 32'h00010);
    tick();
    check("t1_wait_req_low", 32'(bus.o_mem_req), 32'd0);
    repeat (8) tick();
    check("t1_no_early_ack", 32'(bus.o_c0_ack), 32'd0);
    bus.i_mem_wait  = 1'b0;
    bus.i_mem_rdata = 16'hBEEF;
    tick();
    expect_ack("t1");
    bus.i_c0_req    = 1'b0;
    bus.i_mem_wait  = 1'b1;
    bus.i_mem_rdata = 16'h0000;
    repeat (3) tick();
    check("t1_rdata_hold", 32'(bus.o_c_rdata), 32'hBEEF);
    check("t1_idle_ack0",  32'(bus.o_c0_ack),  32'd0);

    // c1 write: command stable from ISSUE through RESP
    bus.i_c1_req   = 1'b1;
    bus.i_c1_wr    = 1'b0;
    bus.i_c1_addr  = 20'hABCDE;
    bus.i_c1_wdata = 16'h1234;
    sb.push_back('{client: 1'b1, rdata: 16'h5555, err: 1'b0});
    tick();
    check("t2_issue", 32'(bus.o_mem_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i),  32'(bus.o_mem_addr), 32'hABCDE);
      check($sformatf("t2_wrdat%0d", i), 32'({bus.o_mem_wr, bus.o_mem_wdata}), 32'h01234);
      tick();
    end
    bus.i_mem_wait  = 1'b0;
    bus.i_mem_rdata = 16'h5555;
    tick();
    check("t2_resp_addr",  32'(bus.o_mem_addr), 32'hABCDE);
    check("t2_resp_wrdat", 32'({bus.o_mem_wr, bus.o_mem_wdata}), 32'h01234);
    expect_ack("t2");
    bus.i_c1_req   = 1'b0;
    bus.i_c1_wr    = 1'b1;
    bus.i_mem_wait = 1'b1;
    tick();

    // reset, then both clients held: c0, c1, c0, c1
    rst = 1'b1;
    #1;
    check_reset_outs("t3_rst");
    tick();
    rst = 1'b0;
    bus.i_c0_req    = 1'b1;  bus.i_c0_addr = 20'h00111;
    bus.i_c1_req    = 1'b1;  bus.i_c1_addr = 20'h00222;
    bus.i_mem_wait  = 1'b0;
    bus.i_mem_rdata = 16'h0C0C;
    for (int k = 0; k < 4; k++)
      sb.push_back('{client: k[0], rdata: 16'h0C0C, err: 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_for_ack($sformatf("t3_rr%0d", k), 10);
      if (k == 3) begin
        bus.i_c0_req = 1'b0;
        bus.i_c1_req = 1'b0;
      end
      tick();
    end
    check("t3_sb_drained", 32'(sb.size()), 32'd0);

    // controller stuck busy: timeout after 31 WAIT cycles
    bus.i_mem_wait  = 1'b1;
    bus.i_mem_rdata = 16'hDEAD;
    bus.i_c0_req    = 1'b1;
    bus.i_c0_addr   = 20'h00003;
    sb.push_back('{client: 1'b0, rdata: 16'h0000, err: 1'b1});
    wait_mem_req("t4", 5);
    n = 0;
    while (!(bus.o_c0_ack || bus.o_c1_ack) && n < 100) begin
      tick();
      n++;
    end
    check("t4_issue_to_ack", 32'(n), 32'd32);
    if (bus.o_c0_ack || bus.o_c1_ack) expect_ack("t4");
    bus.i_c0_req = 1'b0;
    tick();

    // hold blocks the grant; raising it again mid-flight must not abort
    bus.i_hold      = 1'b1;
    bus.i_c0_req    = 1'b1;
    bus.i_c0_addr   = 20'h00077;
    bus.i_mem_wait  = 1'b0;
    bus.i_mem_rdata = 16'h7777;
    sb.push_back('{client: 1'b0, rdata: 16'h7777, err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_hold_noreq%0d", i), 32'(bus.o_mem_req), 32'd0);
    end
    bus.i_hold = 1'b0;
    tick();
    check("t5_issue_after_hold", 32'(bus.o_mem_req), 32'd1);
    bus.i_hold = 1'b1;
    wait_for_ack("t5", 5);
    bus.i_c0_req = 1'b0;
    bus.i_hold   = 1'b0;
    tick();

    // reset during WAIT: no ack, reset outputs, held request served again
    bus.i_mem_wait  = 1'b1;
    bus.i_mem_rdata = 16'h9999;
    bus.i_c1_req    = 1'b1;
    bus.i_c1_addr   = 20'h00099;
    wait_mem_req("t6_pre", 5);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_outs("t6_rst");
    tick();
    check_reset_outs("t6_rst_held");
    rst = 1'b0;
    bus.i_mem_wait = 1'b0;
    sb.push_back('{client: 1'b1, rdata: 16'h9999, err: 1'b0});
    wait_mem_req("t6_post", 5);
    check("t6_post_addr", 32'(bus.o_mem_addr), 32'h00099);
    wait_for_ack("t6", 5);
    bus.i_c1_req = 1'b0;
    tick();
    check("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 31: maximum WAIT-state cycles before a transaction is aborted.
REQ-002 i_clk  in  1  single clock, all state on rising edge.
REQ-003 i_rst  in  1  asynchronous active-high reset.
REQ-004 i_hold  in  1  high = controller busy in autonomous recognition mode; no new grant.
REQ-005 i_c0_req, i_c1_req  in  1 each  client request, level, held until ack.
REQ-006 i_c0_wr, i_c1_wr  in  1 each  1 = read, 0 = write.
REQ-007 i_c0_addr, i_c1_addr  in  20 each  word address.
REQ-008 i_c0_wdata, i_c1_wdata  in  16 each  write data.
REQ-009 o_c0_ack, o_c1_ack  out  1 each  one-cycle completion pulse.
REQ-010 o_c_rdata  out  16  read data, shared, valid while the ack pulse is high.
REQ-011 o_c_err  out  1  timeout flag, valid while the ack pulse is high.
REQ-012 o_mem_req  out  1  one-cycle request to the SRAM controller.
REQ-013 o_mem_wr  out  1  1 = read, 0 = write.
REQ-014 o_mem_addr  out  20  address to the controller.
REQ-015 o_mem_wdata  out  16  write data to the controller.
REQ-016 i_mem_wait  in  1  controller busy.
REQ-017 i_mem_rdata  in  16  controller read data.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if i_hold=0 and any request is high, grant one client, latch its wr/addr/wdata, go to ISSUE; otherwise stay in IDLE.
REQ-020 Arbitration is round-robin on a last-grant pointer (reset value 1):
- Both clients requesting: grant the client not granted last.
- One client requesting: grant that client.
REQ-021 ISSUE lasts exactly one cycle: o_mem_req=1, then go to WAIT.
REQ-022 o_mem_wr, o_mem_addr and o_mem_wdata drive the latched values from ISSUE through RESP, and remain stable.
REQ-023 WAIT: a 5-bit cycle counter clears on entry and increments each WAIT cycle.
- i_mem_wait=0: capture i_mem_rdata, clear err, go to RESP.
- Counter reaches TIMEOUT with i_mem_wait=1: set rdata=0, set err=1, go to RESP.
REQ-024 RESP lasts one cycle: ack of the granted client =1, o_c_rdata and o_c_err valid, then go to IDLE.
REQ-025 Latency: request seen in IDLE at cycle N gives ISSUE at N+1 and WAIT from N+2. i_mem_wait low at cycle M gives ack at M+1.
REQ-026 A client must drop its req in the cycle after its ack. A req still high in that cycle is a new request.
REQ-027 Requests arriving outside IDLE are not lost; they are arbitrated at the next IDLE cycle.
REQ-028 i_hold rising outside IDLE does not abort the transaction in flight.
REQ-029 The two ack outputs are never high together, and at most one transaction is outstanding at any time.
REQ-030 o_c_rdata holds its value between acks.

Reset
REQ-031 Reset gives:
- state IDLE;
- o_mem_req=0, o_mem_wr=1, o_mem_addr=0, o_mem_wdata=0;
- both acks=0, o_c_rdata=0, o_c_err=0;
- counter=0, last-grant pointer=1.
REQ-032 Reset asserted mid-transaction returns to IDLE immediately with no ack issued.

Structure
REQ-033 Shared package sram_arb_pkg holds the state enum, ADDR_W=20, DATA_W=16 and the TIMEOUT default.
REQ-034 The 2-way round-robin picker is sub-module sram_arb_rr, with inputs req[1:0] and last and output grant[1:0].

Verification
REQ-035 c0 read of addr 0x00010, controller wait high 8 cycles, rdata 0xBEEF -> o_mem_req at N+1, o_c0_ack at M+1, o_c_rdata=0xBEEF, o_c_err=0.
REQ-036 c0 and c1 request in the same cycle, both held for repeated transactions -> grant order c0, c1, c0, c1 (pointer reset =1).
REQ-037 c1 write of 0x1234 to 0xABCDE -> o_mem_wr=0, o_mem_addr=0xABCDE, o_mem_wdata=0x1234 stable from ISSUE through RESP.
REQ-038 i_mem_wait stuck high -> ack after 31 WAIT cycles with o_c_err=1 and o_c_rdata=0.
REQ-039 i_hold=1 with c0 requesting -> no o_mem_req; i_hold falls -> ISSUE on the next cycle.
REQ-040 i_rst pulse during WAIT -> IDLE, no ack, all outputs at reset values; a held request is re-served afterwards.
